// File: rtl/rx_packet_monitor.sv
// rx_packet_monitor
// Receive-side checker for the framed GTX test-packet stream. Classifies each
// aligned word, tracks SOP/EOP framing, verifies the payload length and the
// incrementing byte pattern, maintains link-up status, and keeps saturating
// packet/error counters plus a per-window good-packet rate.

module rx_packet_monitor #(
    parameter int unsigned LINK_UP_CNT      = 64,
    parameter int unsigned LINK_DOWN_CYCLES = 1024,
    parameter int unsigned WINDOW_CYCLES    = 156250000
) (
    input  logic        rx_clk,
    input  logic        rst_n,
    input  logic [31:0] gt_rx_data,
    input  logic [3:0]  gt_rx_ctrl,
    input  logic        count_clr,
    output logic        link_up,
    output logic        in_frame,
    output logic [31:0] packet_cnt,
    output logic [31:0] error_packet_cnt,
    output logic [31:0] error_word_cnt,
    output logic [7:0]  last_pkt_type,
    output logic [31:0] pkt_rate
);

    localparam int IDLE_W = $clog2(LINK_UP_CNT + 1);
    localparam int SIL_W  = $clog2(LINK_DOWN_CYCLES + 1);
    localparam int WIN_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

    localparam logic [IDLE_W-1:0] IDLE_TARGET = IDLE_W'(LINK_UP_CNT);
    localparam logic [SIL_W-1:0]  SIL_TARGET  = SIL_W'(LINK_DOWN_CYCLES);
    localparam logic [WIN_W-1:0]  WIN_LAST    = WIN_W'(WINDOW_CYCLES - 1);

    typedef enum logic [2:0] {
        W_IDLE,
        W_SOP,
        W_EOP,
        W_DATA,
        W_BAD
    } word_e;

    typedef enum logic {
        WAIT_SOP,
        PAYLOAD
    } state_e;

    // Saturating +1 used by every 32-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    word_e              word_cls;
    state_e             state_q;
    logic [15:0]        exp_len_q;
    logic [15:0]        word_cnt_q;
    logic [7:0]         exp_byte_q;
    logic               err_flag_q;
    logic [7:0]         last_type_q;
    logic               in_frame_q;

    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [SIL_W-1:0]   sil_cnt_q, sil_cnt_d;
    logic               link_up_q;
    logic               link_rise, link_fall;

    logic               pat_ok, beyond_len;
    logic               good_evt, err_pkt_evt, err_word_evt;

    logic [31:0]        packet_cnt_q, error_packet_cnt_q, error_word_cnt_q;
    logic [31:0]        acc_q, pkt_rate_q;
    logic [WIN_W-1:0]   win_cnt_q;
    logic               win_wrap;

    // Classify the incoming word; anything not explicitly recognised is BAD.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        word_cls = W_BAD;
        if (gt_rx_ctrl == 4'b0000) begin
            word_cls = W_DATA;
        end else if (gt_rx_ctrl == 4'b0001) begin
            case (gt_rx_data[7:0])
                8'hBC:   word_cls = W_IDLE;
                8'hFB:   word_cls = W_SOP;
                8'hFD:   word_cls = W_EOP;
                default: word_cls = W_BAD;
            endcase
        end
    end

    // Next values of the link counters and the link rise/fall conditions.
    always_comb begin
        idle_cnt_d = '0;
        if (word_cls == W_IDLE) begin
            idle_cnt_d = (idle_cnt_q == IDLE_TARGET) ? idle_cnt_q : idle_cnt_q + IDLE_W'(1);
        end
        sil_cnt_d = '0;
        if (!(word_cls inside {W_IDLE, W_SOP, W_EOP})) begin
            sil_cnt_d = (sil_cnt_q == SIL_TARGET) ? sil_cnt_q : sil_cnt_q + SIL_W'(1);
        end
        link_rise = (idle_cnt_d == IDLE_TARGET);
        link_fall = link_up_q && ((word_cls == W_BAD) || (sil_cnt_d == SIL_TARGET));
    end

    // Frame-level counter events; a link drop discards the open packet silently.
    always_comb begin
        pat_ok       = (gt_rx_data == {4{exp_byte_q}});
        beyond_len   = (word_cnt_q >= exp_len_q);
        good_evt     = 1'b0;
        err_pkt_evt  = 1'b0;
        err_word_evt = 1'b0;
        if ((state_q == PAYLOAD) && !link_fall) begin
            case (word_cls)
                W_DATA: err_word_evt = !pat_ok;
                W_EOP: begin
                    if (err_flag_q || (word_cnt_q != exp_len_q)) err_pkt_evt = 1'b1;
                    else                                         good_evt    = 1'b1;
                end
                default: err_pkt_evt = 1'b1;
            endcase
        end
    end

    // Frame FSM: SOP (re)starts a packet from any state; payload words are
    // tracked until EOP or an aborting word returns to WAIT_SOP.
    always_ff @(posedge rx_clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q     <= WAIT_SOP;
            exp_len_q   <= '0;
            word_cnt_q  <= '0;
            exp_byte_q  <= '0;
            err_flag_q  <= 1'b0;
            last_type_q <= '0;
            in_frame_q  <= 1'b0;
        end else if (link_fall) begin
            state_q    <= WAIT_SOP;
            in_frame_q <= 1'b0;
        end else if (word_cls == W_SOP) begin
            state_q     <= PAYLOAD;
            in_frame_q  <= 1'b1;
            exp_len_q   <= gt_rx_data[31:16];
            last_type_q <= gt_rx_data[15:8];
            exp_byte_q  <= 8'h00;
            word_cnt_q  <= '0;
            err_flag_q  <= 1'b0;
        end else if (state_q == PAYLOAD) begin
            if (word_cls == W_DATA) begin
                exp_byte_q <= exp_byte_q + 8'd1;
                if (word_cnt_q != 16'hFFFF) word_cnt_q <= word_cnt_q + 16'd1;
                if (!pat_ok || beyond_len) err_flag_q <= 1'b1;
            end else begin
                state_q    <= WAIT_SOP;
                in_frame_q <= 1'b0;
            end
        end
    end

    // Link monitor: consecutive-idle and silence counters drive link_up.
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
            sil_cnt_q  <= '0;
            link_up_q  <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            sil_cnt_q  <= sil_cnt_d;
            if (link_fall)      link_up_q <= 1'b0;
            else if (link_rise) link_up_q <= 1'b1;
        end
    end

    // Free-running rate window, independent of count_clr.
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) win_cnt_q <= '0;
        else        win_cnt_q <= win_wrap ? '0 : win_cnt_q + WIN_W'(1);
    end

    assign win_wrap = (win_cnt_q == WIN_LAST);

    // Saturating counters and window accumulator; count_clr beats any increment.
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            packet_cnt_q       <= '0;
            error_packet_cnt_q <= '0;
            error_word_cnt_q   <= '0;
            acc_q              <= '0;
            pkt_rate_q         <= '0;
        end else if (count_clr) begin
            packet_cnt_q       <= '0;
            error_packet_cnt_q <= '0;
            error_word_cnt_q   <= '0;
            acc_q              <= '0;
            pkt_rate_q         <= '0;
        end else begin
            packet_cnt_q       <= sat_inc(packet_cnt_q, good_evt);
            error_packet_cnt_q <= sat_inc(error_packet_cnt_q, err_pkt_evt);
            error_word_cnt_q   <= sat_inc(error_word_cnt_q, err_word_evt);
            if (win_wrap) begin
                pkt_rate_q <= sat_inc(acc_q, good_evt);
                acc_q      <= '0;
            end else begin
                acc_q <= sat_inc(acc_q, good_evt);
            end
        end
    end

    assign link_up          = link_up_q;
    assign in_frame         = in_frame_q;
    assign packet_cnt       = packet_cnt_q;
    assign error_packet_cnt = error_packet_cnt_q;
    assign error_word_cnt   = error_word_cnt_q;
    assign last_pkt_type    = last_type_q;
    assign pkt_rate         = pkt_rate_q;

endmodule

// File: tb/tb_rx_packet_monitor.sv
// tb_rx_packet_monitor
// Directed and randomized stimulus for rx_packet_monitor, compared against a
// word-by-word behavioural model of the framing, link and counter rules.

module tb_rx_packet_monitor;

    localparam int LUC = 64;
    localparam int LDC = 1024;
    localparam int WIN = 100;

    logic        rx_clk = 1'b0;
    logic        rst_n  = 1'b0;
    logic [31:0] gt_rx_data = 32'h0000_00BC;
    logic [3:0]  gt_rx_ctrl = 4'b0001;
    logic        count_clr  = 1'b0;
    logic        link_up, in_frame;
    logic [31:0] packet_cnt, error_packet_cnt, error_word_cnt, pkt_rate;
    logic [7:0]  last_pkt_type;

    int n_checks = 0;
    int n_pass   = 0;

    rx_packet_monitor #(
        .LINK_UP_CNT     (LUC),
        .LINK_DOWN_CYCLES(LDC),
        .WINDOW_CYCLES   (WIN)
    ) dut (
        .rx_clk          (rx_clk),
        .rst_n           (rst_n),
        .gt_rx_data      (gt_rx_data),
        .gt_rx_ctrl      (gt_rx_ctrl),
        .count_clr       (count_clr),
        .link_up         (link_up),
        .in_frame        (in_frame),
        .packet_cnt      (packet_cnt),
        .error_packet_cnt(error_packet_cnt),
        .error_word_cnt  (error_word_cnt),
        .last_pkt_type   (last_pkt_type),
        .pkt_rate        (pkt_rate)
    );

    always #5 rx_clk = ~rx_clk;

    // ---------------- behavioural reference model ----------------
    bit         m_in_pkt, m_err, m_link;
    int         m_len, m_pos, m_idle, m_sil;
    longint     m_pkt, m_errp, m_errw, m_acc, m_rate, m_cycle;
    logic [7:0] m_type;

    function automatic longint sat32(input longint v);
        return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
    endfunction

    task automatic model_reset();
        m_in_pkt = 0; m_err = 0; m_link = 0;
        m_len = 0; m_pos = 0; m_idle = 0; m_sil = 0;
        m_pkt = 0; m_errp = 0; m_errw = 0; m_acc = 0; m_rate = 0; m_cycle = 0;
        m_type = 8'h00;
    endtask

    task automatic model_step(input logic [31:0] d, input logic [3:0] c, input bit clr);
        bit is_idle, is_sop, is_eop, is_data, is_bad, fall, good, errp, errw;
        int idle_new, sil_new, pos_sat;
        logic [7:0] b;
        is_data = (c == 4'b0000);
        is_idle = (c == 4'b0001) && (d[7:0] == 8'hBC);
        is_sop  = (c == 4'b0001) && (d[7:0] == 8'hFB);
        is_eop  = (c == 4'b0001) && (d[7:0] == 8'hFD);
        is_bad  = !(is_data || is_idle || is_sop || is_eop);
        idle_new = is_idle ? ((m_idle + 1 > LUC) ? LUC : m_idle + 1) : 0;
        sil_new  = (is_idle || is_sop || is_eop) ? 0 : ((m_sil + 1 > LDC) ? LDC : m_sil + 1);
        fall = m_link && (is_bad || sil_new >= LDC);
        good = 0; errp = 0; errw = 0;
        if (fall) begin
            m_in_pkt = 0;
        end else begin
            if (m_in_pkt) begin
                if (is_data) begin
                    b = 8'(m_pos % 256);
                    if (d !== {4{b}}) begin errw = 1; m_err = 1; end
                    if (m_pos >= m_len) m_err = 1;
                    m_pos++;
                end else if (is_eop) begin
                    pos_sat = (m_pos > 65535) ? 65535 : m_pos;
                    if (m_err || pos_sat != m_len) errp = 1; else good = 1;
                    m_in_pkt = 0;
                end else begin
                    errp = 1;
                    m_in_pkt = 0;
                end
            end
            if (is_sop) begin
                m_in_pkt = 1; m_len = int'(d[31:16]); m_pos = 0; m_err = 0; m_type = d[15:8];
            end
        end
        m_idle = idle_new;
        m_sil  = sil_new;
        if (fall) m_link = 0;
        else if (idle_new >= LUC) m_link = 1;
        if (clr) begin
            m_pkt = 0; m_errp = 0; m_errw = 0; m_acc = 0; m_rate = 0;
        end else begin
            m_pkt  = sat32(m_pkt + longint'(good));
            m_errp = sat32(m_errp + longint'(errp));
            m_errw = sat32(m_errw + longint'(errw));
            m_acc  = sat32(m_acc + longint'(good));
            if (m_cycle % WIN == WIN - 1) begin
                m_rate = m_acc;
                m_acc  = 0;
            end
        end
        m_cycle++;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive_word(input logic [31:0] d, input logic [3:0] c, input bit clr = 1'b0);
        gt_rx_data = d;
        gt_rx_ctrl = c;
        count_clr  = clr;
        model_step(d, c, clr);
        @(posedge rx_clk);
        #1;
        count_clr = 1'b0;
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) drive_word(32'h0000_00BC, 4'b0001);
    endtask

    task automatic send_sop(input logic [7:0] ty, input logic [15:0] len);
        drive_word({len, ty, 8'hFB}, 4'b0001);
    endtask

    task automatic send_payload(input int n);
        for (int i = 0; i < n; i++) drive_word({4{8'(i)}}, 4'b0000);
    endtask

    task automatic send_eop(input bit clr = 1'b0);
        drive_word(32'h0000_00FD, 4'b0001, clr);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(posedge rx_clk);
        #1;
        n_checks++; if (link_up !== 1'b0) $display("FAIL reset_link_up: got %0b want 0", link_up); else n_pass++;
        n_checks++; if (in_frame !== 1'b0) $display("FAIL reset_in_frame: got %0b want 0", in_frame); else n_pass++;
        n_checks++; if (packet_cnt !== 32'd0) $display("FAIL reset_packet_cnt: got %0d want 0", packet_cnt); else n_pass++;
        n_checks++; if (error_packet_cnt !== 32'd0) $display("FAIL reset_error_packet_cnt: got %0d want 0", error_packet_cnt); else n_pass++;
        n_checks++; if (error_word_cnt !== 32'd0) $display("FAIL reset_error_word_cnt: got %0d want 0", error_word_cnt); else n_pass++;
        n_checks++; if (last_pkt_type !== 8'h00) $display("FAIL reset_last_pkt_type: got %0h want 0", last_pkt_type); else n_pass++;
        n_checks++; if (pkt_rate !== 32'd0) $display("FAIL reset_pkt_rate: got %0d want 0", pkt_rate); else n_pass++;
        @(negedge rx_clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_link_up();
        send_idle(LUC - 1);
        n_checks++; if (link_up !== 1'b0) $display("FAIL link_up_early: got %0b want 0 after %0d idles", link_up, LUC - 1); else n_pass++;
        send_idle(1);
        n_checks++; if (link_up !== 1'b1) $display("FAIL link_up_rise: got %0b want 1 after %0d idles", link_up, LUC); else n_pass++;
    endtask

    task automatic test_good_packet();
        send_sop(8'h08, 16'd4);
        n_checks++; if (in_frame !== 1'b1) $display("FAIL good_in_frame: got %0b want 1", in_frame); else n_pass++;
        send_payload(4);
        send_eop();
        n_checks++; if (packet_cnt !== 32'd1) $display("FAIL good_packet_cnt: got %0d want 1", packet_cnt); else n_pass++;
        n_checks++; if (error_packet_cnt !== 32'd0) $display("FAIL good_error_packet_cnt: got %0d want 0", error_packet_cnt); else n_pass++;
        n_checks++; if (last_pkt_type !== 8'h08) $display("FAIL good_last_pkt_type: got %0h want 08", last_pkt_type); else n_pass++;
        n_checks++; if (in_frame !== 1'b0) $display("FAIL good_in_frame_end: got %0b want 0", in_frame); else n_pass++;
    endtask

    task automatic test_word_error();
        send_sop(8'h08, 16'd4);
        drive_word(32'h0000_0000, 4'b0000);
        drive_word(32'h0101_0101, 4'b0000);
        drive_word(32'h0202_0302, 4'b0000);
        drive_word(32'h0303_0303, 4'b0000);
        send_eop();
        n_checks++; if (error_word_cnt !== 32'd1) $display("FAIL werr_error_word_cnt: got %0d want 1", error_word_cnt); else n_pass++;
        n_checks++; if (error_packet_cnt !== 32'd1) $display("FAIL werr_error_packet_cnt: got %0d want 1", error_packet_cnt); else n_pass++;
        n_checks++; if (packet_cnt !== 32'd1) $display("FAIL werr_packet_cnt: got %0d want 1", packet_cnt); else n_pass++;
    endtask

    task automatic test_length();
        send_sop(8'h11, 16'd256);
        send_payload(255);
        send_eop();
        n_checks++; if (error_packet_cnt !== 32'd2) $display("FAIL len_short: got %0d want 2", error_packet_cnt); else n_pass++;
        send_sop(8'h12, 16'd256);
        send_payload(256);
        send_eop();
        n_checks++; if (packet_cnt !== 32'd2) $display("FAIL len_exact: got %0d want 2", packet_cnt); else n_pass++;
        send_sop(8'h13, 16'd300);
        send_payload(300);
        send_eop();
        n_checks++; if (packet_cnt !== 32'd3) $display("FAIL len_wrap: got %0d want 3", packet_cnt); else n_pass++;
        n_checks++; if (error_word_cnt !== 32'd1) $display("FAIL len_wrap_words: got %0d want 1", error_word_cnt); else n_pass++;
        // One word past the declared length, with a correct pattern.
        send_sop(8'h14, 16'd2);
        send_payload(3);
        send_eop();
        n_checks++; if (error_packet_cnt !== 32'd3) $display("FAIL len_long: got %0d want 3", error_packet_cnt); else n_pass++;
        n_checks++; if (error_word_cnt !== 32'd1) $display("FAIL len_long_words: got %0d want 1", error_word_cnt); else n_pass++;
    endtask

    task automatic test_sop_abort();
        send_sop(8'h21, 16'd3);
        send_payload(2);
        send_sop(8'h22, 16'd0);
        n_checks++; if (in_frame !== 1'b1) $display("FAIL abort_in_frame: got %0b want 1", in_frame); else n_pass++;
        send_eop();
        n_checks++; if (error_packet_cnt !== 32'd4) $display("FAIL abort_error_packet_cnt: got %0d want 4", error_packet_cnt); else n_pass++;
        n_checks++; if (packet_cnt !== 32'd4) $display("FAIL abort_packet_cnt: got %0d want 4", packet_cnt); else n_pass++;
        n_checks++; if (last_pkt_type !== 8'h22) $display("FAIL abort_last_pkt_type: got %0h want 22", last_pkt_type); else n_pass++;
        // IDLE inside a payload aborts the packet as an error packet.
        send_sop(8'h23, 16'd4);
        send_payload(1);
        send_idle(1);
        n_checks++; if (error_packet_cnt !== 32'd5) $display("FAIL idle_abort: got %0d want 5", error_packet_cnt); else n_pass++;
        n_checks++; if (in_frame !== 1'b0) $display("FAIL idle_abort_in_frame: got %0b want 0", in_frame); else n_pass++;
    endtask

    task automatic test_clear();
        send_sop(8'h31, 16'd1);
        send_payload(1);
        send_eop(1'b1);
        n_checks++; if (packet_cnt !== 32'd0) $display("FAIL clr_packet_cnt: got %0d want 0", packet_cnt); else n_pass++;
        n_checks++; if (error_packet_cnt !== 32'd0) $display("FAIL clr_error_packet_cnt: got %0d want 0", error_packet_cnt); else n_pass++;
        n_checks++; if (error_word_cnt !== 32'd0) $display("FAIL clr_error_word_cnt: got %0d want 0", error_word_cnt); else n_pass++;
        n_checks++; if (pkt_rate !== 32'd0) $display("FAIL clr_pkt_rate: got %0d want 0", pkt_rate); else n_pass++;
    endtask

    task automatic test_bad_word();
        longint pkt0, errp0;
        pkt0 = m_pkt; errp0 = m_errp;
        send_sop(8'h41, 16'd4);
        send_payload(2);
        drive_word(32'h0000_0000, 4'b0010);
        n_checks++; if (link_up !== 1'b0) $display("FAIL bad_link_up: got %0b want 0", link_up); else n_pass++;
        n_checks++; if (in_frame !== 1'b0) $display("FAIL bad_in_frame: got %0b want 0", in_frame); else n_pass++;
        n_checks++; if (error_packet_cnt !== 32'(errp0)) $display("FAIL bad_discard_err: got %0d want %0d", error_packet_cnt, errp0); else n_pass++;
        n_checks++; if (packet_cnt !== 32'(pkt0)) $display("FAIL bad_discard_good: got %0d want %0d", packet_cnt, pkt0); else n_pass++;
        send_idle(LUC);
        n_checks++; if (link_up !== 1'b1) $display("FAIL bad_relink: got %0b want 1", link_up); else n_pass++;
    endtask

    task automatic test_silence();
        for (int i = 0; i < LDC - 1; i++) drive_word($urandom, 4'b0000);
        n_checks++; if (link_up !== 1'b1) $display("FAIL silence_early: got %0b want 1", link_up); else n_pass++;
        drive_word($urandom, 4'b0000);
        n_checks++; if (link_up !== 1'b0) $display("FAIL silence_drop: got %0b want 0", link_up); else n_pass++;
        send_idle(LUC);
    endtask

    task automatic test_rate();
        while (m_cycle % WIN != 0) send_idle(1);
        for (int p = 0; p < 3; p++) begin
            send_sop(8'h50, 16'd2);
            send_payload(2);
            send_eop();
        end
        while (m_cycle % WIN != WIN - 1) send_idle(1);
        n_checks++; if (pkt_rate !== 32'(m_rate)) $display("FAIL rate_before_wrap: got %0d want %0d", pkt_rate, m_rate); else n_pass++;
        send_idle(1);
        n_checks++; if (pkt_rate !== 32'd3) $display("FAIL rate_three: got %0d want 3", pkt_rate); else n_pass++;
        // Second window: one early packet plus a good EOP on the wrap cycle.
        send_sop(8'h51, 16'd1);
        send_payload(1);
        send_eop();
        while (m_cycle % WIN != WIN - 4) send_idle(1);
        send_sop(8'h52, 16'd2);
        send_payload(2);
        send_eop();
        n_checks++; if (pkt_rate !== 32'd2) $display("FAIL rate_wrap_eop: got %0d want 2", pkt_rate); else n_pass++;
    endtask

    task automatic test_random();
        for (int p = 0; p < 40; p++) begin
            int len, nwords, mode;
            logic [31:0] w, r;
            len    = $urandom_range(0, 12);
            mode   = $urandom_range(0, 7);
            nwords = len;
            if (mode == 1) nwords = len + 1;
            if (mode == 2 && len > 0) nwords = len - 1;
            send_sop(8'($urandom), 16'(len));
            for (int i = 0; i < nwords; i++) begin
                w = {4{8'(i)}};
                if ($urandom_range(0, 7) == 0) w = w ^ (32'd1 << $urandom_range(0, 31));
                drive_word(w, 4'b0000);
            end
            r = $urandom;
            if (mode == 3) send_idle(1);
            else           drive_word({r[31:8], 8'hFD}, 4'b0001);
            n_checks++; if (packet_cnt !== 32'(m_pkt)) $display("FAIL rnd_packet_cnt[%0d]: got %0d want %0d", p, packet_cnt, m_pkt); else n_pass++;
            n_checks++; if (error_packet_cnt !== 32'(m_errp)) $display("FAIL rnd_error_packet_cnt[%0d]: got %0d want %0d", p, error_packet_cnt, m_errp); else n_pass++;
            n_checks++; if (error_word_cnt !== 32'(m_errw)) $display("FAIL rnd_error_word_cnt[%0d]: got %0d want %0d", p, error_word_cnt, m_errw); else n_pass++;
            n_checks++; if (last_pkt_type !== m_type) $display("FAIL rnd_last_pkt_type[%0d]: got %0h want %0h", p, last_pkt_type, m_type); else n_pass++;
            n_checks++; if (link_up !== m_link) $display("FAIL rnd_link_up[%0d]: got %0b want %0b", p, link_up, m_link); else n_pass++;
            n_checks++; if (pkt_rate !== 32'(m_rate)) $display("FAIL rnd_pkt_rate[%0d]: got %0d want %0d", p, pkt_rate, m_rate); else n_pass++;
            send_idle($urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid_packet();
        send_sop(8'h61, 16'd5);
        send_payload(2);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (in_frame !== 1'b0) $display("FAIL rst_mid_in_frame: got %0b want 0", in_frame); else n_pass++;
        n_checks++; if (link_up !== 1'b0) $display("FAIL rst_mid_link_up: got %0b want 0", link_up); else n_pass++;
        n_checks++; if (packet_cnt !== 32'd0) $display("FAIL rst_mid_packet_cnt: got %0d want 0", packet_cnt); else n_pass++;
        @(negedge rx_clk);
        rst_n = 1'b1;
        model_reset();
        send_sop(8'h62, 16'd1);
        send_payload(1);
        send_eop();
        n_checks++; if (packet_cnt !== 32'd1) $display("FAIL rst_mid_first_pkt: got %0d want 1", packet_cnt); else n_pass++;
        n_checks++; if (last_pkt_type !== 8'h62) $display("FAIL rst_mid_type: got %0h want 62", last_pkt_type); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_link_up();
        test_good_packet();
        test_word_error();
        test_length();
        test_sop_abort();
        test_clear();
        test_bad_word();
        test_silence();
        test_rate();
        test_random();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rx_packet_monitor.md
# rx_packet_monitor

Checks the framed test-packet stream on the receive side of the GTX link, directly downstream of the word aligner, in the `rx_clk` domain.
- Tracks frame state, verifies length and the incrementing payload pattern, and maintains link-up status.
- Keeps saturating packet and error counters, plus a per-window packet rate for ILA/register readout.

## Interface
Parameters:
- `LINK_UP_CNT`, 64: consecutive clean idle words required to declare link up.
- `LINK_DOWN_CYCLES`, 1024: cycles without an idle/SOP/EOP word before link is declared down.
- `WINDOW_CYCLES`, 156250000: rate-measurement window length in `rx_clk` cycles.

Ports:
- `rx_clk` input 1: receive user clock; all logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `gt_rx_data` input 32: word-aligned receive data; byte 0 = [7:0], first on wire.
- `gt_rx_ctrl` input 4: K-character flags, bit i for byte i.
- `count_clr` input 1: synchronous clear of all counters; level, sampled each cycle.
- `link_up` output 1: link status.
- `in_frame` output 1: high while between SOP and EOP.
- `packet_cnt` output 32: good packets received.
- `error_packet_cnt` output 32: packets with any error.
- `error_word_cnt` output 32: individual bad payload words.
- `last_pkt_type` output 8: type field of the most recent SOP.
- `pkt_rate` output 32: good packets in the last completed window.

## Operation
Word classes, evaluated combinationally each cycle:
- IDLE: ctrl=4'b0001, data[7:0]=8'hBC.
- SOP: ctrl=4'b0001, data[7:0]=8'hFB; data[15:8]=type, data[31:16]=payload length in words (0 legal).
- EOP: ctrl=4'b0001, data[7:0]=8'hFD; data[31:8] ignored.
- DATA: ctrl=4'b0000.
- BAD: any other ctrl/data combination.

Frame FSM, states WAIT_SOP and PAYLOAD:
- WAIT_SOP:
  - SOP: go to PAYLOAD; load expected length and expected byte 8'h00; clear word count and error flag; latch type into `last_pkt_type`.
  - IDLE, DATA, EOP: stay; no counter effect.
- PAYLOAD:
  - DATA word: it must equal {b,b,b,b}, where b is the expected byte.
    - On mismatch, increment `error_word_cnt` and set the error flag.
    - b increments by 1 mod 256 every DATA word, regardless of mismatch.
    - Word count increments.
  - EOP: if word count ≠ expected length, set the error flag. Then increment `packet_cnt` if the flag is clear, else `error_packet_cnt`. Go to WAIT_SOP.
  - SOP: the current packet is counted as an error packet, and the new packet starts in the same cycle (reload as in WAIT_SOP).
  - IDLE or BAD: the current packet is counted as an error packet; go to WAIT_SOP.
  - DATA beyond the expected length: set the error flag; the word is not counted in `error_word_cnt` unless its pattern also mismatches.
- Word count is 16 bits and saturates at 16'hFFFF.

Link monitor:
- A consecutive-idle counter increments on IDLE and resets on any non-IDLE word.
- `link_up` rises when that counter reaches `LINK_UP_CNT`.
- A silence counter resets on IDLE, SOP or EOP.
- `link_up` falls on any BAD word, or when the silence counter reaches `LINK_DOWN_CYCLES`.
- When `link_up` falls, the FSM is forced to WAIT_SOP and any open packet is discarded uncounted.
- Packet checking runs regardless of `link_up`.

Counters:
- All 32-bit counters saturate at 32'hFFFF_FFFF.
- `count_clr` zeroes `packet_cnt`, `error_packet_cnt`, `error_word_cnt`, `pkt_rate` and the window accumulator.
- If `count_clr` coincides with an increment event, the clear wins (counter = 0).

Rate:
- A window counter counts 0..`WINDOW_CYCLES`-1.
- On wrap, the good-packet accumulator (including a good EOP in the wrap cycle) is copied to `pkt_rate` and restarts from 0.

## Timing
- All outputs are registered.
- Counter and `in_frame` updates appear 1 cycle after the qualifying input word is sampled.
- `link_up` changes 1 cycle after the qualifying condition (Nth idle sampled, BAD sampled, silence count reached).
- `pkt_rate` updates 1 cycle after the window-wrap cycle.
- Reset values: `link_up`=0, `in_frame`=0, all counters 0, `last_pkt_type`=8'h00, `pkt_rate`=0. FSM in WAIT_SOP; expected byte 0.
- Reset assertion mid-packet clears everything immediately; the first SOP after release is handled normally.
- No input handshake: one word is consumed every cycle.

## Test plan
- 64 IDLE words, then SOP(type 8, len 4), DATA 00000000/01010101/02020202/03030303, EOP → `link_up`=1 after the 64th idle; `packet_cnt`=1; `error_packet_cnt`=0; `last_pkt_type`=8'h08.
- Same packet with the third word 02020302 → `error_word_cnt`=1, `error_packet_cnt`=1, `packet_cnt` unchanged.
- SOP len 256 with 255 DATA words then EOP → `error_packet_cnt`+1. Repeat with 256 words → `packet_cnt`+1; byte wraps 8'hFF→8'h00 correctly at word 256 in a len-300 packet.
- SOP, 2 DATA, SOP(len 0), EOP → `error_packet_cnt`=1, `packet_cnt`=1.
- Link up, then ctrl=4'b0010 word → `link_up`=0 next cycle, open packet discarded uncounted. Separately, 1024 DATA-only cycles → `link_up`=0.
- `WINDOW_CYCLES`=100, 3 good packets inside a window → `pkt_rate`=3 one cycle after the wrap. `count_clr` pulsed on an EOP cycle → all counters 0.
